// File: rtl/mem_pkg.sv
// Shared types and constants for the word-organised byte memory and its clients.
package mem_pkg;

  localparam int ADDR_W     = 9;
  localparam int CNT_W      = 7;
  localparam int WORD_BYTES = 4;

  // Lane 0 is the most significant byte of a memory word (bits 31:24).
  typedef logic [7:0] byte_t;
  typedef byte_t [0:WORD_BYTES-1] word_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND,
    FIN
  } state_t;

endpackage

// File: rtl/mem_word_streamer.sv
// Walks a run of consecutive memory words and serialises them into a byte
// stream (lane 0 first) on a valid/ready interface at one byte per cycle.
module mem_word_streamer #(
  parameter int ADDR_W = 9,
  parameter int CNT_W  = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata [0:3],
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  import mem_pkg::*;

  state_t            state, state_d;
  logic [ADDR_W-1:0] ptr, ptr_d;
  logic [CNT_W-1:0]  remaining, remaining_d;
  logic [1:0]        lane, lane_d;
  word_t             word_q, word_d;

  logic              handshake;
  logic              last_lane;
  logic              run_empty;

  // Byte address bits 1:0 are discarded when the run is latched.
  logic              unused_base_low;
  assign unused_base_low = ^base_addr[1:0];

  assign handshake = out_valid && out_ready;
  assign last_lane = (lane == 2'd3);
  assign run_empty = (remaining == '0);

  // Next-state and datapath update: every fetch (LOAD or the lane-3 refill in
  // SEND) reads the word at ptr and advances ptr so the stream never bubbles.
  always_comb begin
    state_d     = state;
    ptr_d       = ptr;
    remaining_d = remaining;
    lane_d      = lane;
    word_d      = word_q;

    unique case (state)
      IDLE: begin
        if (start) begin
          if (word_count != '0) begin
            state_d     = LOAD;
            ptr_d       = {base_addr[ADDR_W-1:2], 2'b00};
            remaining_d = word_count;
          end else begin
            state_d = FIN;
          end
        end
      end

      LOAD: begin
        for (int i = 0; i < WORD_BYTES; i++) begin
          word_d[i] = mem_rdata[i];
        end
        ptr_d       = ptr + ADDR_W'(WORD_BYTES);
        remaining_d = remaining - CNT_W'(1);
        lane_d      = 2'd0;
        state_d     = SEND;
      end

      SEND: begin
        if (handshake) begin
          if (!last_lane) begin
            lane_d = lane + 2'd1;
          end else if (!run_empty) begin
            for (int i = 0; i < WORD_BYTES; i++) begin
              word_d[i] = mem_rdata[i];
            end
            ptr_d       = ptr + ADDR_W'(WORD_BYTES);
            remaining_d = remaining - CNT_W'(1);
            lane_d      = 2'd0;
          end else begin
            state_d = FIN;
          end
        end
      end

      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any run in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      remaining <= '0;
      lane      <= '0;
      word_q    <= '0;
    end else begin
      state     <= state_d;
      ptr       <= ptr_d;
      remaining <= remaining_d;
      lane      <= lane_d;
      word_q    <= word_d;
    end
  end

  // Outputs decode directly from the registered state so reset clears them at once.
  always_comb begin
    mem_addr  = ptr;
    out_valid = (state == SEND);
    out_data  = (state == SEND) ? word_q[lane] : 8'h00;
    out_last  = (state == SEND) && last_lane && run_empty;
    busy      = (state == LOAD) || (state == SEND);
    done      = (state == FIN);
  end

endmodule

// File: tb/tb_mem_word_streamer.sv
// Self-checking bench for mem_word_streamer against a word-list reference model.
module tb_mem_word_streamer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [8:0]  base_addr;
  logic [6:0]  word_count;
  logic [8:0]  mem_addr;
  logic [7:0]  mem_rdata [0:3];
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;
  logic        done;

  logic [31:0] mem [0:127];

  int          vectors     = 0;
  int          miscompares = 0;

  logic [7:0]  exp_bytes [$];
  logic [7:0]  obs_bytes [$];
  logic [8:0]  exp_addr [$];
  logic [8:0]  obs_addr [$];
  int          first_k, last_k, last_h, done_k, last_flags, stall_bad;
  logic        busy_seen, timed_out;

  mem_word_streamer #(.ADDR_W(9), .CNT_W(7)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Combinational memory read, most significant byte on lane 0.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      mem_rdata[i] = mem[mem_addr[8:2]][(31 - 8*i) -: 8];
    end
  end

  // Reference model: the run is a list of words starting at the aligned base,
  // wrapping modulo the 128-word memory, each emitted big-end first.
  function automatic void build_expected(input logic [8:0] base, input int words);
    int idx;
    exp_bytes.delete();
    exp_addr.delete();
    for (int j = 0; j < words; j++) begin
      idx = ((base >> 2) + j) % 128;
      exp_addr.push_back(9'(idx * 4));
      for (int b = 0; b < 4; b++) begin
        exp_bytes.push_back(mem[idx][(31 - 8*b) -: 8]);
      end
    end
  endfunction

  // Pulse start for one edge; afterwards scramble the run inputs, which must not matter.
  task automatic do_start(input logic [8:0] base, input logic [6:0] count);
    start      = 1'b1;
    base_addr  = base;
    word_count = count;
    @(posedge clk); #1;
    start      = 1'b0;
    base_addr  = 9'($urandom);
    word_count = 7'($urandom);
  endtask

  // Observe one run from the cycle after the start edge (k = 0) until done.
  // mode 0: ready high, 1: ready pattern 1,0,0, 2: random ready.
  task automatic capture_run(input int mode, input int words, input int restart_k,
                             input logic [8:0] restart_base);
    int         h;
    logic       held_v;
    logic [7:0] held;
    obs_bytes.delete();
    obs_addr.delete();
    first_k = -1; last_k = -1; last_h = -1; done_k = -1;
    last_flags = 0; stall_bad = 0; busy_seen = 1'b0; timed_out = 1'b0;
    h = 0; held_v = 1'b0; held = 8'h00;
    for (int k = 0; k < 400; k++) begin
      start = (k == restart_k);
      if (k == restart_k) begin
        base_addr  = restart_base;
        word_count = 7'd5;
      end
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (k % 3 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (held_v && out_valid && out_data !== held) stall_bad++;
      if (busy) busy_seen = 1'b1;
      if (done) begin
        done_k = k;
        break;
      end
      if (busy && !out_valid && h == 0 && obs_addr.size() == 0) obs_addr.push_back(mem_addr);
      if (out_valid && out_ready) begin
        if (first_k < 0) first_k = k;
        obs_bytes.push_back(out_data);
        if (out_last) begin
          last_flags++;
          last_k = k;
          last_h = h;
        end
        if (h % 4 == 3 && h != 4*words - 1) obs_addr.push_back(mem_addr);
        h++;
        held_v = 1'b0;
      end else if (out_valid) begin
        held_v = 1'b1;
        held   = out_data;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    if (done_k < 0) timed_out = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; base_addr = '0; word_count = '0; out_ready = 1'b0;
    #12;
    vectors++;
    if ({mem_addr, out_data, out_valid, out_last, busy, done} !== 21'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got addr=%0d data=%h v=%b l=%b busy=%b done=%b required all 0",
               mem_addr, out_data, out_valid, out_last, busy, done);
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({out_valid, busy, done} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL idle_after_reset: got v=%b busy=%b done=%b required 000", out_valid, busy, done);
    end
  endtask

  task automatic test_basic();
    mem[4] = 32'h11223344;
    mem[5] = 32'hAABBCCDD;
    build_expected(9'd16, 2);
    do_start(9'd16, 7'd2);
    capture_run(0, 2, -1, 9'd0);
    vectors++;
    if (timed_out !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_timeout: got timeout required done"); end
    vectors++;
    if (obs_bytes.size() !== 8) begin
      miscompares++; $display("[TB] FAIL basic_len: got %0d required 8", obs_bytes.size());
    end
    foreach (exp_bytes[i]) if (i < obs_bytes.size()) begin
      vectors++;
      if (obs_bytes[i] !== exp_bytes[i]) begin
        miscompares++; $display("[TB] FAIL basic_byte%0d: got %h required %h", i, obs_bytes[i], exp_bytes[i]);
      end
    end
    vectors++;
    if (first_k !== 1) begin miscompares++; $display("[TB] FAIL basic_latency: got k=%0d required 1", first_k); end
    vectors++;
    if (last_k !== 8 || last_flags !== 1) begin
      miscompares++; $display("[TB] FAIL basic_last: got k=%0d count=%0d required k=8 count=1", last_k, last_flags);
    end
    vectors++;
    if (done_k !== 9) begin miscompares++; $display("[TB] FAIL basic_done: got k=%0d required 9", done_k); end
    @(posedge clk); #1;
    vectors++;
    if ({done, busy, out_valid} !== 3'b000) begin
      miscompares++; $display("[TB] FAIL basic_done_pulse: got done=%b busy=%b v=%b required 000", done, busy, out_valid);
    end
  endtask

  task automatic test_backpressure();
    build_expected(9'd16, 2);
    do_start(9'd16, 7'd2);
    capture_run(1, 2, -1, 9'd0);
    vectors++;
    if (timed_out !== 1'b0 || obs_bytes.size() !== 8) begin
      miscompares++; $display("[TB] FAIL bp_len: got %0d handshakes timeout=%b required 8", obs_bytes.size(), timed_out);
    end
    foreach (exp_bytes[i]) if (i < obs_bytes.size()) begin
      vectors++;
      if (obs_bytes[i] !== exp_bytes[i]) begin
        miscompares++; $display("[TB] FAIL bp_byte%0d: got %h required %h", i, obs_bytes[i], exp_bytes[i]);
      end
    end
    vectors++;
    if (stall_bad !== 0) begin miscompares++; $display("[TB] FAIL bp_stable: got %0d changes required 0", stall_bad); end
    vectors++;
    if (done_k !== last_k + 1 || last_h !== 7) begin
      miscompares++; $display("[TB] FAIL bp_last_done: got done_k=%0d last_k=%0d last_h=%0d required done_k=last_k+1 last_h=7",
                              done_k, last_k, last_h);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_zero_count();
    do_start(9'd40, 7'd0);
    capture_run(0, 0, -1, 9'd0);
    vectors++;
    if (done_k !== 0) begin miscompares++; $display("[TB] FAIL zero_done: got k=%0d required 0", done_k); end
    vectors++;
    if (busy_seen !== 1'b0 || obs_bytes.size() !== 0) begin
      miscompares++; $display("[TB] FAIL zero_quiet: got busy=%b bytes=%0d required 0 0", busy_seen, obs_bytes.size());
    end
    @(posedge clk); #1;
    vectors++;
    if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL zero_pulse: got done=%b required 0", done); end
  endtask

  task automatic test_wrap();
    mem[127] = 32'hC0FFEE01;
    mem[0]   = 32'h5A6B7C8D;
    build_expected(9'd510, 2);
    do_start(9'd510, 7'd2);
    capture_run(0, 2, -1, 9'd0);
    vectors++;
    if (obs_addr.size() !== 2) begin
      miscompares++; $display("[TB] FAIL wrap_addr_count: got %0d required 2", obs_addr.size());
    end else begin
      vectors++;
      if (obs_addr[0] !== 9'd508 || obs_addr[1] !== 9'd0) begin
        miscompares++; $display("[TB] FAIL wrap_addr: got %0d,%0d required 508,0", obs_addr[0], obs_addr[1]);
      end
    end
    foreach (exp_bytes[i]) if (i < obs_bytes.size()) begin
      vectors++;
      if (obs_bytes[i] !== exp_bytes[i]) begin
        miscompares++; $display("[TB] FAIL wrap_byte%0d: got %h required %h", i, obs_bytes[i], exp_bytes[i]);
      end
    end
    vectors++;
    if (obs_bytes.size() !== 8 || done_k !== 9) begin
      miscompares++; $display("[TB] FAIL wrap_len: got bytes=%0d done_k=%0d required 8 9", obs_bytes.size(), done_k);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run();
    logic saw_done;
    logic [8:0] base;
    base = 9'($urandom_range(0, 511));
    build_expected(base, 3);
    out_ready = 1'b1;
    do_start(base, 7'd3);
    repeat (3) begin @(posedge clk); #1; end
    vectors++;
    if (out_valid !== 1'b1 || out_data !== exp_bytes[2]) begin
      miscompares++; $display("[TB] FAIL mid_byte3: got v=%b data=%h required 1 %h", out_valid, out_data, exp_bytes[2]);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({mem_addr, out_data, out_valid, out_last, busy, done} !== 21'd0) begin
      miscompares++;
      $display("[TB] FAIL mid_async_clear: got addr=%0d data=%h v=%b l=%b busy=%b done=%b required all 0",
               mem_addr, out_data, out_valid, out_last, busy, done);
    end
    saw_done = 1'b0;
    repeat (2) begin @(posedge clk); #1; if (done) saw_done = 1'b1; end
    rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; if (done) saw_done = 1'b1; end
    vectors++;
    if (saw_done !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_no_done: got done pulse required none"); end
    base = 9'($urandom_range(0, 511));
    build_expected(base, 1);
    do_start(base, 7'd1);
    capture_run(0, 1, -1, 9'd0);
    vectors++;
    if (obs_bytes.size() !== 4 || done_k !== 5) begin
      miscompares++; $display("[TB] FAIL mid_restart_len: got bytes=%0d done_k=%0d required 4 5", obs_bytes.size(), done_k);
    end
    foreach (exp_bytes[i]) if (i < obs_bytes.size()) begin
      vectors++;
      if (obs_bytes[i] !== exp_bytes[i]) begin
        miscompares++; $display("[TB] FAIL mid_restart_byte%0d: got %h required %h", i, obs_bytes[i], exp_bytes[i]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_start_while_busy();
    logic [8:0] base;
    base = 9'($urandom_range(0, 511));
    build_expected(base, 3);
    do_start(base, 7'd3);
    capture_run(0, 3, 5, base + 9'd64);
    vectors++;
    if (obs_bytes.size() !== 12 || done_k !== 13) begin
      miscompares++; $display("[TB] FAIL busy_start_len: got bytes=%0d done_k=%0d required 12 13", obs_bytes.size(), done_k);
    end
    foreach (exp_bytes[i]) if (i < obs_bytes.size()) begin
      vectors++;
      if (obs_bytes[i] !== exp_bytes[i]) begin
        miscompares++; $display("[TB] FAIL busy_start_byte%0d: got %h required %h", i, obs_bytes[i], exp_bytes[i]);
      end
    end
    repeat (2) begin @(posedge clk); #1; end
    vectors++;
    if ({busy, out_valid} !== 2'b00) begin
      miscompares++; $display("[TB] FAIL busy_start_idle: got busy=%b v=%b required 00", busy, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] base;
    int         words;
    for (int r = 0; r < 6; r++) begin
      base  = 9'($urandom_range(0, 511));
      words = $urandom_range(1, 6);
      build_expected(base, words);
      do_start(base, 7'(words));
      capture_run(2, words, -1, 9'd0);
      vectors++;
      if (timed_out !== 1'b0 || obs_bytes.size() !== 4*words) begin
        miscompares++; $display("[TB] FAIL rand%0d_len: got %0d timeout=%b required %0d", r, obs_bytes.size(), timed_out, 4*words);
      end
      foreach (exp_bytes[i]) if (i < obs_bytes.size()) begin
        vectors++;
        if (obs_bytes[i] !== exp_bytes[i]) begin
          miscompares++; $display("[TB] FAIL rand%0d_byte%0d: got %h required %h", r, i, obs_bytes[i], exp_bytes[i]);
        end
      end
      foreach (exp_addr[i]) if (i < obs_addr.size()) begin
        vectors++;
        if (obs_addr[i] !== exp_addr[i]) begin
          miscompares++; $display("[TB] FAIL rand%0d_addr%0d: got %0d required %0d", r, i, obs_addr[i], exp_addr[i]);
        end
      end
      vectors++;
      if (last_flags !== 1 || last_h !== 4*words - 1 || done_k !== last_k + 1 || stall_bad !== 0) begin
        miscompares++;
        $display("[TB] FAIL rand%0d_ctrl: got lasts=%0d last_h=%0d done_k=%0d last_k=%0d stalls=%0d required 1 %0d last_k+1 0",
                 r, last_flags, last_h, done_k, last_k, stall_bad, 4*words - 1);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = $urandom;
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_count();
    test_wrap();
    test_reset_mid_run();
    test_start_while_busy();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
